mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter sharing one single-port memory/IO bus between `N_CORES` PicoRV32 harts using the PicoRV32 native memory interface (valid/ready). It sits between the cores and the on-chip RAM/LED/UART decode and replaces free-running counter arbitration with a request-driven grant. A bus-ready timeout keeps a hung peripheral from stalling every hart.

## Interface
- `N_CORES`, 2, number of requesters, 1..8.
- `CORE_BITS`, `$clog2(N_CORES)` (min 1), width of core index.
- `TIMEOUT`, 255, max cycles waiting for `bus_ready`; 0 disables timeout; max 65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `core_valid` in N_CORES: per-core request, held until that core's `core_ready`.
- `core_addr` in 32*N_CORES: byte address, core i at [32*i+31 -: 32].
- `core_wdata` in 32*N_CORES: write data.
- `core_wstrb` in 4*N_CORES: byte enables; 0 = read.
- `core_ready` out N_CORES: one-cycle completion pulse, one-hot or zero.
- `core_rdata` out 32*N_CORES: read data, valid with `core_ready`; only the completed slice is updated.
- `bus_valid` out 1: downstream request.
- `bus_addr` out 32, `bus_wdata` out 32, `bus_wstrb` out 4: registered copy of the granted request.
- `bus_ready` in 1: downstream completion, one cycle.
- `bus_rdata` in 32: sampled when `bus_ready` is high.
- `grant_id` out CORE_BITS: index of current/last grant.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: if any `core_valid`, pick the winner with round-robin, searching from `(last+1) mod N_CORES` upward with wrap. Latch addr/wdata/wstrb, set `last`/`grant_id`, raise `bus_valid`, then go to BUS. With no request, stay in IDLE.
- BUS: hold `bus_*` stable.
  - On `bus_ready`: capture `bus_rdata` into the winner's `core_rdata` slice, drop `bus_valid`, go to RESP.
  - If `TIMEOUT`≠0 and the wait counter reaches `TIMEOUT` without `bus_ready`: write rdata slice = 32'h0, pulse `err`, drop `bus_valid`, go to RESP.
- RESP: `core_ready[winner]`=1 for exactly this cycle, then return to IDLE. Requests are not sampled in RESP, so the completing core's still-high valid is never re-granted.
- `core_valid` falling while in BUS is ignored, because PicoRV32 never does this. The transaction completes normally.
- `bus_ready` in IDLE or RESP is ignored.
- Simultaneous requests: exactly one is granted. A requester waits at most N_CORES-1 transactions (fairness).
- Wait counter: 16 bits, cleared on entry to BUS, saturating.

Reset values (async on `resetn`=0, bus aborted immediately):
- state = IDLE
- `bus_valid`=0, `bus_addr`/`bus_wdata`=0, `bus_wstrb`=0
- `core_ready`=0, `core_rdata`=0, `err`=0
- `last`=N_CORES-1, so core 0 wins first
- `grant_id`=N_CORES-1

## Timing
- Valid seen at edge 0 → `bus_valid` high cycle 1.
- `bus_ready` in cycle k → `core_ready` high cycle k+1 → IDLE in cycle k+2.
- Minimum transaction: 3 cycles (IDLE→BUS→RESP) with zero-wait bus. Back-to-back grants every 3 cycles.
- Timeout: `err` and `core_ready` coincide in RESP, TIMEOUT+2 cycles after `bus_valid` rose.
- All outputs are registered; no combinational path from `core_*` or `bus_*` inputs to outputs.

## Structure
- Package `mem_arb_pkg`: state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2), `RDATA_ON_TIMEOUT`=32'h0, counter width 16.
- Sub-module `rr_pick`: combinational, takes (`req[N_CORES]`, `last`) and returns (`any`, `winner`). It is reused by future interrupt/mcompose arbiters.

## Test plan
- Single read, core 0, addr 0x100, `bus_ready` one cycle after `bus_valid` with rdata 0xCAFEF00D → `core_ready[0]` pulse exactly one cycle later, `core_rdata[31:0]`=0xCAFEF00D, `core_ready[1]` never high.
- Both cores request continuously from reset → grants alternate 0,1,0,1; no core waits more than one transaction; grant spacing 3 cycles.
- Core 1 write, wstrb 4'b0011, wdata 0x12345678 → bus shows identical addr/wdata/wstrb stable for the whole BUS state; `core_rdata[63:32]` set to `bus_rdata`.
- `TIMEOUT`=4, `bus_ready` held low → `err` pulse and `core_ready` in the same cycle, 6 cycles after `bus_valid` rose; rdata=0. The next request is granted normally.
- `resetn` pulled low mid-BUS → `bus_valid` drops asynchronously. After release, the first grant goes to core 0.
- Spurious `bus_ready` in IDLE with no requests → no `core_ready` and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM encoding, timeout read data, wait counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Read data returned to a core whose transaction was abandoned on timeout.
  localparam logic [31:0] RDATA_ON_TIMEOUT = 32'h0000_0000;

  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester found searching upward from last+1 with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the pick is consumed.
//
// Ports:
//   req    - one request bit per requester
//   last   - index of the previously granted requester
//   any    - at least one request is present
//   winner - index of the chosen requester (equals last when any is low)
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N_CORES   = 2,
  parameter int CORE_BITS = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic [N_CORES-1:0]   req,
  input  logic [CORE_BITS-1:0] last,
  output logic                 any,
  output logic [CORE_BITS-1:0] winner
);

  always_comb begin
    any    = 1'b0;
    winner = last;
    // Offset N_CORES wraps back onto last itself, so a lone repeat requester still wins.
    for (int k = 1; k <= N_CORES; k++) begin
      if (!any && req[(int'(last) + k) % N_CORES]) begin
        any    = 1'b1;
        winner = CORE_BITS'((int'(last) + k) % N_CORES);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between N_CORES PicoRV32 harts.
// Latency: request seen -> bus_valid next cycle; bus_ready -> core_ready next cycle; 3 cycles min per transaction.
// Backpressure: cores hold valid until their one-cycle ready; a bus stuck without ready is abandoned after TIMEOUT.
//
// Ports:
//   clk, resetn                         - clock and async active-low reset
//   core_valid/addr/wdata/wstrb         - per-core request, packed 32/32/4 bits per core
//   core_ready, core_rdata              - per-core completion pulse and read data slice
//   bus_valid/addr/wdata/wstrb          - registered downstream request
//   bus_ready, bus_rdata                - downstream completion and read data
//   grant_id                            - index of current/last grant
//   err                                 - one-cycle pulse when a transaction times out
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CORES   = 2,
  parameter int CORE_BITS = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_CORES-1:0]      core_valid,
  input  logic [32*N_CORES-1:0]   core_addr,
  input  logic [32*N_CORES-1:0]   core_wdata,
  input  logic [4*N_CORES-1:0]    core_wstrb,
  output logic [N_CORES-1:0]      core_ready,
  output logic [32*N_CORES-1:0]   core_rdata,
  output logic                    bus_valid,
  output logic [31:0]             bus_addr,
  output logic [31:0]             bus_wdata,
  output logic [3:0]              bus_wstrb,
  input  logic                    bus_ready,
  input  logic [31:0]             bus_rdata,
  output logic [CORE_BITS-1:0]    grant_id,
  output logic                    err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_L = WAIT_CNT_W'(TIMEOUT);

  arb_state_t             state, state_nxt;
  logic                   pick_any;
  logic [CORE_BITS-1:0]   pick_id;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  // Registered "counter reached TIMEOUT" flag: keeps the 16-bit compare out of the
  // next-state path and gives the bus one final cycle to answer before abandoning.
  logic                   timeout_hit;

  // grant_id doubles as the round-robin "last" pointer.
  rr_pick #(
    .N_CORES   (N_CORES),
    .CORE_BITS (CORE_BITS)
  ) u_rr_pick (
    .req    (core_valid),
    .last   (grant_id),
    .any    (pick_any),
    .winner (pick_id)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = BUS;
      BUS:     if (bus_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_valid   <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      core_ready  <= '0;
      core_rdata  <= '0;
      err         <= 1'b0;
      grant_id    <= CORE_BITS'(N_CORES - 1);
      wait_cnt    <= '0;
      timeout_hit <= 1'b0;
    end else begin
      core_ready <= '0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id    <= pick_id;
            bus_addr    <= core_addr[32*int'(pick_id) +: 32];
            bus_wdata   <= core_wdata[32*int'(pick_id) +: 32];
            bus_wstrb   <= core_wstrb[4*int'(pick_id) +: 4];
            bus_valid   <= 1'b1;
            wait_cnt    <= '0;
            timeout_hit <= 1'b0;
          end
        end
        BUS: begin
          if (bus_ready) begin
            core_rdata[32*int'(grant_id) +: 32] <= bus_rdata;
            core_ready[grant_id]                <= 1'b1;
            bus_valid                           <= 1'b0;
          end else if (timeout_hit) begin
            core_rdata[32*int'(grant_id) +: 32] <= RDATA_ON_TIMEOUT;
            core_ready[grant_id]                <= 1'b1;
            err                                 <= 1'b1;
            bus_valid                           <= 1'b0;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            timeout_hit <= (TIMEOUT != 0) && (wait_cnt == TIMEOUT_L);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (N_CORES=2, TIMEOUT=4).
// Latency: n/a.
// Backpressure: bench drives bus_ready directly.
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int CB = 1;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    core_valid;
  logic [32*N-1:0] core_addr;
  logic [32*N-1:0] core_wdata;
  logic [4*N-1:0]  core_wstrb;
  logic [N-1:0]    core_ready;
  logic [32*N-1:0] core_rdata;
  logic            bus_valid;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [3:0]      bus_wstrb;
  logic            bus_ready;
  logic [31:0]     bus_rdata;
  logic [CB-1:0]   grant_id;
  logic            err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .N_CORES   (N),
    .CORE_BITS (CB),
    .TIMEOUT   (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .core_valid (core_valid),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wstrb (core_wstrb),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .grant_id   (grant_id),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_rd;
    int          exp_g;

    resetn     = 1'b0;
    core_valid = '0;
    core_addr  = '0;
    core_wdata = '0;
    core_wstrb = '0;
    bus_ready  = 1'b0;
    bus_rdata  = '0;

    // ---- reset state
    tick();
    tick();
    check("rst_bus_valid",  64'(bus_valid),  64'd0);
    check("rst_bus_addr",   64'(bus_addr),   64'd0);
    check("rst_bus_wstrb",  64'(bus_wstrb),  64'd0);
    check("rst_core_ready", 64'(core_ready), 64'd0);
    check("rst_core_rdata", 64'(core_rdata), 64'd0);
    check("rst_err",        64'(err),        64'd0);
    check("rst_grant_id",   64'(grant_id),   64'd1);
    resetn = 1'b1;

    // ---- single read, core 0, answered in the first BUS cycle
    core_valid      = 2'b01;
    core_addr[31:0] = 32'h0000_0100;
    tick();
    check("rd_bus_valid", 64'(bus_valid), 64'd1);
    check("rd_bus_addr",  64'(bus_addr),  64'h100);
    check("rd_bus_wstrb", 64'(bus_wstrb), 64'd0);
    check("rd_grant",     64'(grant_id),  64'd0);
    check("rd_no_ready",  64'(core_ready), 64'd0);
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    tick();
    check("rd_core_ready", 64'(core_ready), 64'b01);
    check("rd_rdata0",     64'(core_rdata[31:0]), 64'hCAFE_F00D);
    check("rd_bus_drop",   64'(bus_valid), 64'd0);
    bus_ready = 1'b0;
    // core still holds valid through RESP; it must not be re-granted
    tick();
    check("rd_ready_once", 64'(core_ready), 64'd0);
    check("rd_idle",       64'(bus_valid),  64'd0);
    core_valid = 2'b00;
    tick();
    check("rd_no_regrant", 64'(bus_valid), 64'd0);

    // ---- spurious bus_ready in IDLE
    bus_ready = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ready = 1'b0;
    check("spur_ready", 64'(core_ready), 64'd0);
    check("spur_valid", 64'(bus_valid),  64'd0);
    check("spur_rdata", 64'(core_rdata[31:0]), 64'hCAFE_F00D);
    tick();
    check("spur_still_idle", 64'(bus_valid), 64'd0);

    // ---- core 1 write with two wait cycles
    core_valid        = 2'b10;
    core_addr[63:32]  = 32'h2000_0040;
    core_wdata[63:32] = 32'h1234_5678;
    core_wstrb[7:4]   = 4'b0011;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_valid_%0d", i), 64'(bus_valid), 64'd1);
      check($sformatf("wr_addr_%0d", i),  64'(bus_addr),  64'h2000_0040);
      check($sformatf("wr_wdata_%0d", i), 64'(bus_wdata), 64'h1234_5678);
      check($sformatf("wr_wstrb_%0d", i), 64'(bus_wstrb), 64'b0011);
      check($sformatf("wr_grant_%0d", i), 64'(grant_id),  64'd1);
      if (i == 2) begin
        bus_ready = 1'b1;
        bus_rdata = 32'hA5A5_0001;
      end
      tick();
    end
    bus_ready = 1'b0;
    check("wr_core_ready", 64'(core_ready), 64'b10);
    check("wr_rdata1",     64'(core_rdata[63:32]), 64'hA5A5_0001);
    check("wr_rdata0_kept", 64'(core_rdata[31:0]), 64'hCAFE_F00D);
    check("wr_err",        64'(err), 64'd0);
    tick();
    core_valid = 2'b00;
    tick();

    // ---- both cores request continuously from reset, zero-wait bus
    do_reset();
    core_addr  = {32'h0000_2222, 32'h0000_1111};
    core_valid = 2'b11;
    bus_ready  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_g  = t % 2;
      exp_rd = 32'h5000_0000 + 32'(t);
      bus_rdata = exp_rd;
      tick();
      check($sformatf("rr_valid_%0d", t), 64'(bus_valid), 64'd1);
      check($sformatf("rr_grant_%0d", t), 64'(grant_id),  64'(exp_g));
      check($sformatf("rr_addr_%0d", t),  64'(bus_addr),  (exp_g == 0) ? 64'h1111 : 64'h2222);
      tick();
      check($sformatf("rr_ready_%0d", t), 64'(core_ready), 64'(1 << exp_g));
      check($sformatf("rr_rdata_%0d", t),
            64'((exp_g == 0) ? core_rdata[31:0] : core_rdata[63:32]), 64'(exp_rd));
      tick();
      check($sformatf("rr_gap_%0d", t), 64'(bus_valid | |core_ready), 64'd0);
    end
    core_valid = 2'b00;
    bus_ready  = 1'b0;
    tick();

    // ---- timeout: bus_ready never comes
    core_valid      = 2'b01;
    core_addr[31:0] = 32'h0000_0300;
    tick();
    check("to_grant", 64'(grant_id), 64'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("to_wait_valid_%0d", c), 64'(bus_valid),  64'd1);
      check($sformatf("to_wait_err_%0d", c),   64'(err),        64'd0);
      check($sformatf("to_wait_ready_%0d", c), 64'(core_ready), 64'd0);
    end
    tick();
    check("to_err",   64'(err),              64'd1);
    check("to_ready", 64'(core_ready),       64'b01);
    check("to_rdata", 64'(core_rdata[31:0]), 64'd0);
    check("to_drop",  64'(bus_valid),        64'd0);
    tick();
    check("to_err_pulse", 64'(err), 64'd0);
    core_valid = 2'b10;
    bus_ready  = 1'b1;
    bus_rdata  = 32'h7777_0002;
    tick();
    check("post_to_grant", 64'(grant_id),  64'd1);
    check("post_to_valid", 64'(bus_valid), 64'd1);
    tick();
    check("post_to_ready", 64'(core_ready), 64'b10);
    check("post_to_rdata", 64'(core_rdata[63:32]), 64'h7777_0002);
    check("post_to_noerr", 64'(err), 64'd0);
    bus_ready = 1'b0;
    tick();
    core_valid = 2'b00;
    tick();

    // ---- reset mid-BUS drops bus_valid without a clock edge
    core_valid = 2'b10;
    tick();
    check("mid_valid", 64'(bus_valid), 64'd1);
    #3;
    resetn = 1'b0;
    #1;
    check("async_drop",  64'(bus_valid), 64'd0);
    check("async_grant", 64'(grant_id),  64'd1);
    tick();
    core_valid = 2'b11;
    resetn     = 1'b1;
    tick();
    check("after_rst_grant", 64'(grant_id),  64'd0);
    check("after_rst_addr",  64'(bus_addr),  64'h300);
    bus_ready = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    tick();
    check("after_rst_ready", 64'(core_ready), 64'b01);
    bus_ready  = 1'b0;
    core_valid = 2'b00;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
